// File: rtl/arb_router_4x4.sv
// Round-robin 4x4 router: pops one word from a non-empty upstream FIFO and
// pushes it to the downstream FIFO named by the word's top two bits.
module arb_router_4x4 #(
    parameter int DATA_SIZE = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           fifo_empty_in,
    input  logic [DATA_SIZE-1:0] data_in0,
    input  logic [DATA_SIZE-1:0] data_in1,
    input  logic [DATA_SIZE-1:0] data_in2,
    input  logic [DATA_SIZE-1:0] data_in3,
    input  logic [3:0]           pause_in,
    output logic [3:0]           pop,
    output logic [3:0]           push,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 busy,
    output logic [7:0]           xfer_count,
    output logic [1:0]           dbg_state
);

    // Handshake: pop[i] is a one-cycle read strobe, data_in[i] is valid the
    // following cycle; push[j] is a one-cycle write strobe qualified by
    // pause_in[j] being low in the cycle the push is decided.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_POP     = 2'd1,
        S_CAPTURE = 2'd2,
        S_PUSH    = 2'd3
    } state_t;

    state_t               r_state;
    logic [1:0]           r_last_grant;
    logic [1:0]           r_grant;
    logic [DATA_SIZE-1:0] r_hold;
    logic [3:0]           r_pop;
    logic [3:0]           r_push;
    logic [DATA_SIZE-1:0] r_data_out;
    logic                 r_busy;
    logic [7:0]           r_xfer_count;

    logic [3:0]           w_req;
    logic                 w_grant_valid;
    logic [1:0]           w_grant;
    logic [1:0]           w_idx;
    logic [DATA_SIZE-1:0] w_data_sel;
    logic [1:0]           w_cap_dest;
    logic [1:0]           w_hold_dest;

    assign w_req       = ~fifo_empty_in;
    assign w_cap_dest  = w_data_sel[DATA_SIZE-1:DATA_SIZE-2];
    assign w_hold_dest = r_hold[DATA_SIZE-1:DATA_SIZE-2];

    // Scan from lowest to highest priority so the nearest requester after
    // last_grant is the final one written.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant       = 2'd0;
        w_idx         = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_last_grant + 2'(k + 1);
            if (w_req[w_idx]) begin
                w_grant_valid = 1'b1;
                w_grant       = w_idx;
            end
        end
    end

    always_comb begin
        case (r_grant)
            2'd0:    w_data_sel = data_in0;
            2'd1:    w_data_sel = data_in1;
            2'd2:    w_data_sel = data_in2;
            default: w_data_sel = data_in3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 2'd3;
            r_grant      <= 2'd0;
            r_hold       <= '0;
            r_pop        <= 4'b0000;
            r_push       <= 4'b0000;
            r_data_out   <= '0;
            r_busy       <= 1'b0;
            r_xfer_count <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_valid && (pause_in == 4'b0000)) begin
                        r_grant      <= w_grant;
                        r_last_grant <= w_grant;
                        r_pop        <= 4'b0001 << w_grant;
                        r_busy       <= 1'b1;
                        r_state      <= S_POP;
                    end
                end
                S_POP: begin
                    r_pop   <= 4'b0000;
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    // Push is decided here so it is visible in the first PUSH cycle.
                    r_hold  <= w_data_sel;
                    r_state <= S_PUSH;
                    if (!pause_in[w_cap_dest]) begin
                        r_push       <= 4'b0001 << w_cap_dest;
                        r_data_out   <= w_data_sel;
                        r_xfer_count <= r_xfer_count + 8'd1;
                    end
                end
                default: begin
                    if (r_push != 4'b0000) begin
                        r_push  <= 4'b0000;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (!pause_in[w_hold_dest]) begin
                        r_push       <= 4'b0001 << w_hold_dest;
                        r_data_out   <= r_hold;
                        r_xfer_count <= r_xfer_count + 8'd1;
                    end
                end
            endcase
        end
    end

    assign pop        = r_pop;
    assign push       = r_push;
    assign data_out   = r_data_out;
    assign busy       = r_busy;
    assign xfer_count = r_xfer_count;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_arb_router_4x4.sv
// Bench for arb_router_4x4: emulated upstream FIFOs, a transaction-level
// reference model compared every cycle, and directed scenarios with literals.
module tb_arb_router_4x4;
    localparam int DS = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    fifo_empty_in = 4'hF;
    logic [DS-1:0] data_in_a [4] = '{default: '0};
    logic [3:0]    pause_in = 4'b0000;
    logic [3:0]    pop;
    logic [3:0]    push;
    logic [DS-1:0] data_out;
    logic          busy;
    logic [7:0]    xfer_count;
    logic [1:0]    dbg_state;

    arb_router_4x4 #(.DATA_SIZE(DS)) dut (
        .clk(clk), .reset(reset), .fifo_empty_in(fifo_empty_in),
        .data_in0(data_in_a[0]), .data_in1(data_in_a[1]),
        .data_in2(data_in_a[2]), .data_in3(data_in_a[3]),
        .pause_in(pause_in), .pop(pop), .push(push), .data_out(data_out),
        .busy(busy), .xfer_count(xfer_count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Upstream FIFO contents and monitor records
    logic [DS-1:0] up_q [4][$];
    logic [1:0]    pop_log[$];
    logic [1:0]    exp_q[$];
    int            last_pop_cyc = 0;
    int            push_cnt = 0;

    // Reference model: transaction view of one word in flight
    bit            m_valid = 0;
    bit            m_busy = 0;
    bit            m_pushed = 0;
    int            m_age = 0;
    int            m_last = 3;
    int            m_port = 0;
    logic [DS-1:0] m_word = '0;
    logic [3:0]    e_pop = 0, e_push = 0;
    logic [DS-1:0] e_dout = 0;
    logic [7:0]    e_cnt = 0;
    logic          e_busy = 0;

    task automatic model_try_push();
        int dest;
        dest = int'(m_word[DS-1:DS-2]);
        if (!pause_in[dest]) begin
            e_push   = 4'(1) << dest;
            e_dout   = m_word;
            e_cnt    = e_cnt + 8'd1;
            m_pushed = 1;
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_valid = 1; m_busy = 0; m_pushed = 0; m_last = 3;
            e_pop = 0; e_push = 0; e_dout = 0; e_cnt = 0; e_busy = 0;
        end else if (m_valid) begin
            e_pop  = 0;
            e_push = 0;
            if (!m_busy) begin
                if (pause_in == 4'b0000 && fifo_empty_in != 4'hF) begin
                    bit found;
                    found = 0;
                    for (int k = 1; k <= 4; k++) begin
                        int p;
                        p = (m_last + k) % 4;
                        if (!found && !fifo_empty_in[p]) begin
                            found  = 1;
                            m_port = p;
                        end
                    end
                    m_last = m_port; m_busy = 1; m_age = 0; m_pushed = 0;
                    e_pop = 4'(1) << m_port;
                end
            end else begin
                m_age++;
                if (m_pushed) m_busy = 0;
                else if (m_age == 2) begin
                    m_word = data_in_a[m_port];
                    model_try_push();
                end else if (m_age > 2) model_try_push();
            end
            e_busy = m_busy;
        end
    end

    // Compare, monitor, then let the emulated FIFOs respond to pop
    always @(negedge clk) begin
        if (m_valid) begin
            chk("pop", pop, e_pop);
            chk("push", push, e_push);
            chk("data_out", data_out, e_dout);
            chk("busy", busy, e_busy);
            chk("xfer_count", xfer_count, e_cnt);
            chk("onehot", ($countones(pop) <= 1) && ($countones(push) <= 1)
                          && !((pop != 0) && (push != 0)), 1);
        end
        if (push != 0) push_cnt++;
        for (int i = 0; i < 4; i++) begin
            if (pop[i]) begin
                pop_log.push_back(2'(i));
                last_pop_cyc = cyc;
                chk("pop_nonempty", up_q[i].size() > 0, 1);
                if (up_q[i].size() > 0) data_in_a[i] = up_q[i].pop_front();
            end
            fifo_empty_in[i] = (up_q[i].size() == 0);
        end
    end

    task automatic load(input int p, input logic [DS-1:0] w);
        up_q[p].push_back(w);
    endtask

    task automatic wait_push(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (push == 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (push == 0) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_pop(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (pop == 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (pop == 0) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_pop", pop, 4'b0000);
        chk("rst_push", push, 4'b0000);
        chk("rst_dout", data_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", xfer_count, 0);
        reset = 1'b0;

        // Single word to destination 2
        load(0, 10'b10_0000_0101);
        wait_push("single");
        chk("single_push", push, 4'b0100);
        chk("single_dout", data_out, 10'h205);
        chk("single_cnt", xfer_count, 8'd1);
        chk("single_port", pop_log[pop_log.size()-1], 2'd0);
        chk("single_lat", cyc - last_pop_cyc, 2);

        // Fairness after reset: port 0 first, then rotation
        pulse_reset();
        pop_log.delete();
        for (int p = 0; p < 4; p++) begin
            load(p, {2'(p + 1), 8'(8'h10 * p + 1)});
            load(p, {2'(3 - p), 8'(8'h10 * p + 2)});
        end
        for (int t = 0; t < 8; t++) wait_push("fair");
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        chk("fair_len", pop_log.size(), 8);
        for (int t = 0; t < 8 && t < pop_log.size(); t++) chk("fair_order", pop_log[t], exp_q[t]);
        chk("fair_cnt", xfer_count, 8'd8);

        // Upstream pause blocks arbitration
        @(negedge clk);
        pause_in = 4'b0001;
        pop_log.delete();
        for (int p = 0; p < 4; p++) load(p, {2'(p), 8'hA0 + 8'(p)});
        repeat (6) @(negedge clk);
        chk("upause_pops", pop_log.size(), 0);
        chk("upause_busy", busy, 0);
        pause_in = 4'b0000;
        @(negedge clk);
        chk("upause_grant", pop, 4'b0001);
        for (int t = 0; t < 4; t++) wait_push("upause");
        chk("upause_cnt", xfer_count, 8'd12);

        // Destination stall on port 3 for 5 cycles
        load(1, 10'h3AB);
        wait_pop("stall");
        @(negedge clk);
        pause_in = 4'b1000;
        repeat (5) @(negedge clk);
        pause_in = 4'b0000;
        wait_push("stall");
        chk("stall_push", push, 4'b1000);
        chk("stall_dout", data_out, 10'h3AB);
        chk("stall_len", cyc - last_pop_cyc - 2, 5);

        // Reset during CAPTURE drops the word
        load(2, 10'h1C3);
        wait_pop("mid");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_pop", pop, 0);
        chk("mid_push", push, 0);
        chk("mid_dout", data_out, 0);
        chk("mid_busy", busy, 0);
        chk("mid_cnt", xfer_count, 0);
        n = push_cnt;
        repeat (8) @(negedge clk);
        chk("mid_nopush", push_cnt, n);

        // Counter wrap
        for (int t = 0; t < 257; t++) load(t % 4, {2'(t / 4), 8'(t)});
        for (int t = 0; t < 256; t++) wait_push("wrap");
        chk("wrap_256", xfer_count, 8'd0);
        wait_push("wrap");
        chk("wrap_257", xfer_count, 8'd1);
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
